// File: rtl/timer_ctrl_if.sv
// Button, datapath-status and digit-control signals between the timer
// sequencer (slave) and its surroundings (master: debounce front end / digit chain).
interface timer_ctrl_if;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_stop;
  logic       btn_set;
  logic       mode_up;
  logic       cnt_zero;
  logic       cnt_max;
  logic       tick;
  logic       set_time;
  logic       run;
  logic       pause;
  logic       stop;
  logic       UpOrDown;
  logic       alarm;
  logic [2:0] state;

  modport master (
    output btn_start, btn_pause, btn_stop, btn_set, mode_up, cnt_zero, cnt_max,
    input  tick, set_time, run, pause, stop, UpOrDown, alarm, state
  );

  modport slave (
    input  btn_start, btn_pause, btn_stop, btn_set, mode_up, cnt_zero, cnt_max,
    output tick, set_time, run, pause, stop, UpOrDown, alarm, state
  );
endinterface

// File: rtl/timer_ctrl.sv
// Sequencer for the BCD timer: button FSM, count-tick prescaler, direction latch, alarm.
// Define TIMER_CTRL_AUTORELOAD_EN to reload the digits on terminal count instead of expiring.
module timer_ctrl #(
  parameter int TICK_DIV     = 50,
  parameter int ALARM_CYCLES = 8
) (
  input  logic        Clk,
  input  logic        reset,
  timer_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);
`ifdef TIMER_CTRL_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSED  = 3'd3,
    S_EXPIRED = 3'd4,
    S_STOPPED = 3'd5
  } state_t;

  state_t        r_state, w_next;
  logic [PW-1:0] r_presc, w_presc;
  logic [AW-1:0] r_alarm_cnt, w_alarm_cnt;
  logic          r_up, w_up;
  logic          r_tick, r_set_time, r_run, r_pause, r_stop, r_alarm;
  logic          w_tick, w_reload, w_alarm_load, w_adv, w_term, w_alarm, w_keep_alarm;

  assign w_term = r_up ? bus.cnt_max : bus.cnt_zero;

  // Next state: only the highest-priority pressed button is considered (stop > set > pause > start).
  always_comb begin
    w_next       = r_state;
    w_presc      = r_presc;
    w_up         = r_up;
    w_tick       = 1'b0;
    w_reload     = 1'b0;
    w_alarm_load = 1'b0;
    w_adv        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.btn_stop) begin
          w_next = S_IDLE;
        end else if (bus.btn_set) begin
          w_next = S_LOAD;
        end else if (bus.btn_pause) begin
          w_next = S_IDLE;
        end else if (bus.btn_start) begin
          w_next  = S_RUN;
          w_up    = bus.mode_up;
          w_presc = '0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        w_next = S_IDLE;
        w_up   = bus.mode_up;
      end
      S_RUN: begin
        if (bus.btn_stop) begin
          w_next = S_STOPPED;
        end else if (bus.btn_pause && !bus.btn_set) begin
          w_next = S_PAUSED;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_PAUSED: begin
        if (bus.btn_stop) begin
          w_next = S_STOPPED;
        end else if (bus.btn_set) begin
          w_next = S_PAUSED;
        end else if (bus.btn_pause || bus.btn_start) begin
          w_adv = 1'b1;
        end else begin
          w_next = S_PAUSED;
        end
      end
      S_EXPIRED: begin
        if (bus.btn_stop) begin
          w_next = S_IDLE;
        end else if (bus.btn_set) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_EXPIRED;
        end
      end
      S_STOPPED: begin
        if (bus.btn_stop) begin
          w_next = S_STOPPED;
        end else if (bus.btn_set) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_STOPPED;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // A counting edge (in RUN, or the edge resuming from PAUSED) advances the prescaler.
    if (w_adv) begin
      w_next = S_RUN;
      if (r_presc == PRESC_LAST) begin
        w_presc = '0;
        if (w_term) begin
          w_alarm_load = 1'b1;
          if (AUTORELOAD) begin
            w_reload = 1'b1;
          end else begin
            w_next = S_EXPIRED;
          end
        end else begin
          w_tick = 1'b1;
        end
      end else begin
        w_presc = r_presc + PW'(1);
      end
    end else begin
      w_presc = w_presc;
    end
  end

  assign w_keep_alarm = AUTORELOAD ? 1'b1 : (w_next == S_EXPIRED);

  // Alarm window: counter holds the number of high cycles still owed after the current one.
  always_comb begin
    w_alarm     = 1'b0;
    w_alarm_cnt = '0;
    if (w_alarm_load) begin
      w_alarm     = 1'b1;
      w_alarm_cnt = ALARM_LAST;
    end else if (r_alarm && (r_alarm_cnt != '0) && w_keep_alarm) begin
      w_alarm     = 1'b1;
      w_alarm_cnt = r_alarm_cnt - AW'(1);
    end else begin
      w_alarm     = 1'b0;
      w_alarm_cnt = '0;
    end
  end

  // State, datapath registers and Moore outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_alarm_cnt <= '0;
      r_up        <= 1'b1;
      r_tick      <= 1'b0;
      r_set_time  <= 1'b0;
      r_run       <= 1'b0;
      r_pause     <= 1'b0;
      r_stop      <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_presc     <= w_presc;
      r_alarm_cnt <= w_alarm_cnt;
      r_up        <= w_up;
      r_tick      <= w_tick;
      r_set_time  <= (w_next == S_LOAD) || w_reload;
      r_run       <= (w_next == S_RUN) || (w_next == S_PAUSED);
      r_pause     <= (w_next == S_PAUSED);
      r_stop      <= (w_next == S_STOPPED);
      r_alarm     <= w_alarm;
    end
  end

  assign bus.tick     = r_tick;
  assign bus.set_time = r_set_time;
  assign bus.run      = r_run;
  assign bus.pause    = r_pause;
  assign bus.stop     = r_stop;
  assign bus.UpOrDown = r_up;
  assign bus.alarm    = r_alarm;
  assign bus.state    = r_state;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4, ALARM_CYCLES=3.
module tb_timer_ctrl;
  logic Clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  timer_ctrl_if bus_if ();

  timer_ctrl #(.TICK_DIV(4), .ALARM_CYCLES(3)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_btn();
    bus_if.btn_start = 1'b0;
    bus_if.btn_pause = 1'b0;
    bus_if.btn_stop  = 1'b0;
    bus_if.btn_set   = 1'b0;
  endtask

  initial begin
    clr_btn();
    bus_if.mode_up  = 1'b0;
    bus_if.cnt_zero = 1'b0;
    bus_if.cnt_max  = 1'b0;

    // reset values, checked before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_state", 32'(bus_if.state), 32'd0);
    chk("rst_tick", 32'(bus_if.tick), 32'd0);
    chk("rst_set_time", 32'(bus_if.set_time), 32'd0);
    chk("rst_run", 32'(bus_if.run), 32'd0);
    chk("rst_pause", 32'(bus_if.pause), 32'd0);
    chk("rst_stop", 32'(bus_if.stop), 32'd0);
    chk("rst_alarm", 32'(bus_if.alarm), 32'd0);
    chk("rst_updown", 32'(bus_if.UpOrDown), 32'd1);
    step();
    step();
    reset = 1'b0;

    // IDLE: pause outranks start and is illegal, so start is not taken
    bus_if.btn_pause = 1'b1;
    bus_if.btn_start = 1'b1;
    step();
    clr_btn();
    chk("idle_prio_state", 32'(bus_if.state), 32'd0);

    // start counting down
    bus_if.btn_start = 1'b1;
    step();
    clr_btn();
    chk("start_state", 32'(bus_if.state), 32'd2);
    chk("start_run", 32'(bus_if.run), 32'd1);
    chk("start_updown", 32'(bus_if.UpOrDown), 32'd0);
    chk("start_tick0", 32'(bus_if.tick), 32'd0);
    bus_if.mode_up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("run_tick_c%0d", k), 32'(bus_if.tick), ((k % 4) == 0) ? 32'd1 : 32'd0);
    end
    chk("run_updown_held", 32'(bus_if.UpOrDown), 32'd0);
    bus_if.mode_up = 1'b0;

    // pause at the second counting edge, hold 10 cycles, resume
    step();
    bus_if.btn_pause = 1'b1;
    step();
    clr_btn();
    chk("pause_state", 32'(bus_if.state), 32'd3);
    chk("pause_level", 32'(bus_if.pause), 32'd1);
    chk("pause_run", 32'(bus_if.run), 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("paused_tick_%0d", k), 32'(bus_if.tick), 32'd0);
      chk($sformatf("paused_state_%0d", k), 32'(bus_if.state), 32'd3);
    end
    bus_if.btn_pause = 1'b1;
    step();
    clr_btn();
    chk("resume_state", 32'(bus_if.state), 32'd2);
    chk("resume_pause", 32'(bus_if.pause), 32'd0);
    chk("resume_tick_c0", 32'(bus_if.tick), 32'd0);
    step();
    chk("resume_tick_c1", 32'(bus_if.tick), 32'd0);
    step();
    chk("resume_tick_c2", 32'(bus_if.tick), 32'd1);
    step();
    chk("resume_tick_c3", 32'(bus_if.tick), 32'd0);

`ifndef TIMER_CTRL_AUTORELOAD_EN
    // expiry: cnt_zero seen at the next wrap edge (two edges away)
    bus_if.cnt_zero = 1'b1;
    step();
    chk("exp_pre1_state", 32'(bus_if.state), 32'd2);
    step();
    chk("exp_pre2_state", 32'(bus_if.state), 32'd2);
    step();
    chk("exp_state", 32'(bus_if.state), 32'd4);
    chk("exp_tick", 32'(bus_if.tick), 32'd0);
    chk("exp_run", 32'(bus_if.run), 32'd0);
    chk("exp_alarm_c0", 32'(bus_if.alarm), 32'd1);
    step();
    chk("exp_alarm_c1", 32'(bus_if.alarm), 32'd1);
    step();
    chk("exp_alarm_c2", 32'(bus_if.alarm), 32'd1);
    step();
    chk("exp_alarm_c3", 32'(bus_if.alarm), 32'd0);
    chk("exp_hold_state", 32'(bus_if.state), 32'd4);
    step();
    chk("exp_alarm_c4", 32'(bus_if.alarm), 32'd0);
    bus_if.cnt_zero = 1'b0;
    bus_if.btn_stop = 1'b1;
    step();
    clr_btn();
    chk("ack_state", 32'(bus_if.state), 32'd0);
`else
    // return to IDLE via stop and reload
    bus_if.btn_stop = 1'b1;
    step();
    clr_btn();
    bus_if.btn_set = 1'b1;
    step();
    clr_btn();
    step();
    chk("ar_back_idle", 32'(bus_if.state), 32'd0);
`endif

    // priority: stop beats pause in RUN; STOPPED ignores start and stop+set
    bus_if.mode_up   = 1'b1;
    bus_if.btn_start = 1'b1;
    step();
    clr_btn();
    chk("prio_run_updown", 32'(bus_if.UpOrDown), 32'd1);
    bus_if.btn_stop  = 1'b1;
    bus_if.btn_pause = 1'b1;
    step();
    clr_btn();
    chk("prio_state", 32'(bus_if.state), 32'd5);
    chk("prio_stop", 32'(bus_if.stop), 32'd1);
    chk("prio_run", 32'(bus_if.run), 32'd0);
    chk("prio_pause", 32'(bus_if.pause), 32'd0);
    bus_if.btn_start = 1'b1;
    step();
    clr_btn();
    chk("stopped_start_ign", 32'(bus_if.state), 32'd5);
    bus_if.btn_stop = 1'b1;
    bus_if.btn_set  = 1'b1;
    step();
    clr_btn();
    chk("stopped_no_subst", 32'(bus_if.state), 32'd5);
    bus_if.mode_up = 1'b0;
    bus_if.btn_set = 1'b1;
    step();
    clr_btn();
    chk("load_state", 32'(bus_if.state), 32'd1);
    chk("load_set_time", 32'(bus_if.set_time), 32'd1);
    chk("load_stop", 32'(bus_if.stop), 32'd0);
    step();
    chk("after_load_state", 32'(bus_if.state), 32'd0);
    chk("after_load_set_time", 32'(bus_if.set_time), 32'd0);
    chk("after_load_updown", 32'(bus_if.UpOrDown), 32'd0);
    bus_if.mode_up = 1'b1;
    step();
    chk("idle_updown_held", 32'(bus_if.UpOrDown), 32'd0);

    // asynchronous reset while tick is high
    bus_if.mode_up   = 1'b0;
    bus_if.btn_start = 1'b1;
    step();
    clr_btn();
    step();
    step();
    step();
    step();
    chk("mid_run_tick", 32'(bus_if.tick), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_state", 32'(bus_if.state), 32'd0);
    chk("arst_tick", 32'(bus_if.tick), 32'd0);
    chk("arst_run", 32'(bus_if.run), 32'd0);
    chk("arst_updown", 32'(bus_if.UpOrDown), 32'd1);
    #1 reset = 1'b0;
    step();
    chk("post_rst_state", 32'(bus_if.state), 32'd0);

`ifdef TIMER_CTRL_AUTORELOAD_EN
    // auto-reload on cnt_max while counting up
    bus_if.mode_up   = 1'b1;
    bus_if.cnt_max   = 1'b1;
    bus_if.btn_start = 1'b1;
    step();
    clr_btn();
    step();
    step();
    step();
    step();
    chk("ar_state", 32'(bus_if.state), 32'd2);
    chk("ar_set_time", 32'(bus_if.set_time), 32'd1);
    chk("ar_tick", 32'(bus_if.tick), 32'd0);
    chk("ar_alarm_c0", 32'(bus_if.alarm), 32'd1);
    bus_if.cnt_max = 1'b0;
    step();
    chk("ar_set_time_c1", 32'(bus_if.set_time), 32'd0);
    chk("ar_alarm_c1", 32'(bus_if.alarm), 32'd1);
    step();
    chk("ar_alarm_c2", 32'(bus_if.alarm), 32'd1);
    step();
    chk("ar_alarm_c3", 32'(bus_if.alarm), 32'd0);
    step();
    chk("ar_next_tick", 32'(bus_if.tick), 32'd1);
    chk("ar_state_run", 32'(bus_if.state), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the BCD timer datapath (chained timer10-style digit counters). Turns single-cycle button pulses into the run/pause/stop/set_time levels the digit cells consume. Generates the prescaled count tick, latches count direction, detects terminal count from datapath status flags, and raises a timed alarm. Sits between the button-debounce front end and the digit chain.

## Interface
- TICK_DIV, 50: clock cycles per count tick; must be ≥2. Prescaler width is $clog2(TICK_DIV).
- ALARM_CYCLES, 8: cycles `alarm` stays high on expiry; must be ≥1.
- Clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- btn_start  in  1  one-cycle start/resume request.
- btn_pause  in  1  one-cycle pause toggle request.
- btn_stop  in  1  one-cycle stop / acknowledge request.
- btn_set  in  1  one-cycle reload request.
- mode_up  in  1  requested direction: 1 = up, 0 = down.
- cnt_zero  in  1  datapath: all digits 0.
- cnt_max  in  1  datapath: all digits at max.
- tick  out  1  one-cycle count-enable pulse to the digit chain.
- set_time  out  1  one-cycle digit reload pulse.
- run  out  1  start level to the digits.
- pause  out  1  pause level to the digits.
- stop  out  1  stop level to the digits.
- UpOrDown  out  1  latched direction.
- alarm  out  1  expiry indication.
- state  out  3  encoded FSM state.

## Operation
- FSM states: IDLE=0, LOAD=1, RUN=2, PAUSED=3, EXPIRED=4, STOPPED=5. Codes 6 and 7 recover to IDLE on the next edge.
- Button priority in the same cycle: stop > set > pause > start. A button not legal in the current state is ignored; the next-priority button is not substituted.
- IDLE:
  - btn_set → LOAD.
  - btn_start → RUN. Latches `UpOrDown <= mode_up` and clears the prescaler.
- LOAD: lasts one cycle with set_time=1. Latches `UpOrDown <= mode_up`. Then → IDLE.
- RUN:
  - Prescaler increments each cycle.
  - At presc==TICK_DIV-1 (the wrap edge), presc ← 0 and tick=1 in the following cycle.
  - Terminal = UpOrDown ? cnt_max : cnt_zero, sampled at the wrap edge. If terminal: no tick, → EXPIRED, alarm counter loaded.
  - btn_pause → PAUSED.
  - btn_stop → STOPPED.
  - Both buttons override terminal.
- PAUSED:
  - Prescaler holds its value.
  - btn_pause or btn_start → RUN, resuming from the held value.
  - btn_stop → STOPPED.
- EXPIRED:
  - alarm=1 for exactly ALARM_CYCLES cycles, then 0; the state remains EXPIRED.
  - btn_set → LOAD.
  - btn_stop → IDLE (acknowledge).
- STOPPED: btn_set → LOAD. btn_start and btn_pause are ignored.
- Output levels:
  - run=1 in RUN and PAUSED.
  - pause=1 in PAUSED.
  - stop=1 in STOPPED.
  - mode_up is ignored outside the IDLE→RUN transition and LOAD.

## Timing
- All outputs are registered (Moore): each changes on the edge that enters or leaves the owning state.
- Reset values: state=0, tick=0, set_time=0, run=0, pause=0, stop=0, alarm=0, UpOrDown=1, prescaler=0, alarm counter=0.
- Reset is asynchronous. Asserting it mid-operation forces all outputs to their reset values without waiting for a Clk edge.
- First tick is high in the TICK_DIV-th cycle after RUN entry; subsequent ticks occur every TICK_DIV cycles.
- Tick spacing is preserved across pause: cycles spent in PAUSED are excluded from the count.
- A pause at the wrap edge holds presc=TICK_DIV-1, so the resume edge is itself a wrap edge.
- set_time is high for exactly one cycle per LOAD (or per auto-reload).
- Button-to-state latency is 1 cycle.

## Configuration
- TIMER_CTRL_AUTORELOAD_EN defined: terminal in RUN does not leave RUN.
  - That wrap edge issues set_time=1 for one cycle instead of tick.
  - The prescaler keeps running.
  - alarm still pulses for ALARM_CYCLES cycles.
  - A second terminal during the alarm window reloads the alarm counter.
  - EXPIRED becomes unreachable.
- TIMER_CTRL_AUTORELOAD_EN undefined: terminal → EXPIRED, as described above.

## Test plan
Defaults for all scenarios: TICK_DIV=4, ALARM_CYCLES=3.
- Start: reset, mode_up=0, cnt_zero=0, btn_start → state=2, run=1, UpOrDown=0, tick high in cycles 4, 8 and 12 after entry, never for 2 consecutive cycles.
- Pause/resume: btn_pause 2 cycles into RUN, wait 10 cycles, btn_pause → state=3 and pause=1 while paused, no tick while paused, next tick 2 cycles after resume.
- Expiry: cnt_zero=1 before a wrap edge → state=4, no tick that cycle, run=0, alarm high exactly 3 cycles; btn_stop → state=0.
- Priority: btn_stop and btn_pause in the same RUN cycle → state=5, stop=1; btn_start ignored; btn_set → one cycle state=1 with set_time=1, then state=0.
- Reset mid-RUN: pulse reset between edges → all outputs 0 and state=0 before the next Clk edge, UpOrDown=1.
- Auto-reload (macro defined): cnt_max=1, mode_up=1 → state stays 2, set_time high 1 cycle instead of tick, alarm high 3 cycles, ticks continue 4 cycles later.
